// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a two-entry skid buffer, valid/ready handshake,
// synchronous flush and NOP bubbles. Optional stall/flush counters under `PIPE_STATS_EN`.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  input  logic [CTRL_W-1:0] In_Ctrl,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  output logic [CTRL_W-1:0] Out_Ctrl
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]       Stall_Cnt,
  output logic [15:0]       Flush_Cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_m_data;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_s_data;
  logic [CTRL_W-1:0]   r_s_ctrl;

  logic                w_out_valid;
  logic                w_accept;
  logic                w_take;
  logic                w_load_m_in;
  logic                w_load_m_skid;
  logic                w_load_s;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = In_Valid & r_in_ready;
  assign w_take      = w_out_valid & Out_Ready;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt   = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    if (Flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_load_m_in = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && w_take) begin
            w_load_m_in = 1'b1;
          end else if (w_take) begin
            w_state_nxt = ST_EMPTY;
          end else if (w_accept) begin
            w_load_s    = 1'b1;
            w_state_nxt = ST_SKID;
          end
        end
        ST_SKID: begin
          // Ready is low here, so nothing can be accepted; the skid entry moves up on take.
          if (w_take) begin
            w_load_m_skid = 1'b1;
            w_state_nxt   = ST_FULL;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge Clk) begin
    // NOTE: payload registers are reset too, because Out_Data must read zero after reset.
    if (Reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_m_data   <= '0;
      r_m_ctrl   <= '0;
      r_s_data   <= '0;
      r_s_ctrl   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_SKID);
      if (w_load_m_in) begin
        r_m_data <= In_Data;
        r_m_ctrl <= In_Ctrl;
      end else if (w_load_m_skid) begin
        r_m_data <= r_s_data;
        r_m_ctrl <= r_s_ctrl;
      end
      if (w_load_s) begin
        r_s_data <= In_Data;
        r_s_ctrl <= In_Ctrl;
      end
    end
  end

  assign In_Ready  = r_in_ready;
  assign Out_Valid = w_out_valid;
  assign Out_Data  = r_m_data;
  // Bubbles must look like NOPs downstream, so control is gated by valid.
  assign Out_Ctrl  = w_out_valid ? r_m_ctrl : '0;

`ifdef PIPE_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out_valid && !Out_Ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (Flush && w_out_valid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;

  logic              Clk;
  logic              Reset;
  logic              Flush;
  logic              In_Valid;
  logic              In_Ready;
  logic [DATA_W-1:0] In_Data;
  logic [CTRL_W-1:0] In_Ctrl;
  logic              Out_Valid;
  logic              Out_Ready;
  logic [DATA_W-1:0] Out_Data;
  logic [CTRL_W-1:0] Out_Ctrl;
`ifdef PIPE_STATS_EN
  logic [31:0]       Stall_Cnt;
  logic [15:0]       Flush_Cnt;
`endif

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Data   (In_Data),
    .In_Ctrl   (In_Ctrl),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Data  (Out_Data),
    .Out_Ctrl  (Out_Ctrl)
`ifdef PIPE_STATS_EN
    ,
    .Stall_Cnt (Stall_Cnt),
    .Flush_Cnt (Flush_Cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a FIFO of at most two beats plus the last head payload.
  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } beat_t;

  beat_t             mq[$];
  logic [DATA_W-1:0] m_last_data;
  longint            m_stall;
  longint            m_flush;
  bit                chk_en = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      mq.delete();
      m_last_data = '0;
      m_stall     = 0;
      m_flush     = 0;
    end else begin
      bit acc;
      bit tk;
      if (mq.size() > 0 && !Out_Ready && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (Flush && mq.size() > 0 && m_flush < 64'hFFFF) m_flush++;
      if (Flush) begin
        mq.delete();
      end else begin
        acc = In_Valid && (mq.size() < 2);
        tk  = (mq.size() > 0) && Out_Ready;
        if (tk) void'(mq.pop_front());
        if (acc) mq.push_back('{d: In_Data, c: In_Ctrl});
      end
      if (mq.size() > 0) m_last_data = mq[0].d;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("mdl_out_valid", 64'(Out_Valid), 64'(mq.size() > 0));
      check("mdl_in_ready", 64'(In_Ready), 64'(mq.size() < 2));
      check("mdl_out_data", 64'(Out_Data), 64'(m_last_data));
      check("mdl_out_ctrl", 64'(Out_Ctrl), (mq.size() > 0) ? 64'(mq[0].c) : 64'd0);
`ifdef PIPE_STATS_EN
      check("mdl_stall_cnt", 64'(Stall_Cnt), 64'(m_stall));
      check("mdl_flush_cnt", 64'(Flush_Cnt), 64'(m_flush));
`endif
    end
  end

  task automatic drive(input bit v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input bit ordy, input bit fl, input bit rst);
    In_Valid  = v;
    In_Data   = d;
    In_Ctrl   = c;
    Out_Ready = ordy;
    Flush     = fl;
    Reset     = rst;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    drive(0, '0, '0, 0, 0, 1);
    step();
    chk_en = 1'b1;

    // Reset state
    check("rst_out_valid", 64'(Out_Valid), 64'd0);
    check("rst_out_data", 64'(Out_Data), 64'd0);
    check("rst_out_ctrl", 64'(Out_Ctrl), 64'd0);
    check("rst_in_ready", 64'(In_Ready), 64'd1);

    // Streaming 1..8 with no gaps
    for (int i = 1; i <= 8; i++) begin
      drive(1, DATA_W'(i), 8'h11, 1, 0, 0);
      step();
      check("stream_valid", 64'(Out_Valid), 64'd1);
      check("stream_data", 64'(Out_Data), 64'(i));
      check("stream_ctrl", 64'(Out_Ctrl), 64'h11);
    end
    drive(0, '0, 8'h11, 1, 0, 0);
    step();
    check("stream_drain_valid", 64'(Out_Valid), 64'd0);
    check("stream_drain_ctrl", 64'(Out_Ctrl), 64'd0);
    check("stream_drain_data_held", 64'(Out_Data), 64'd8);

    // Back-pressure into the skid entry
    drive(1, 32'hA, 8'h0A, 1, 0, 0);
    step();
    check("skid_a_out", 64'(Out_Data), 64'hA);
    drive(1, 32'hB, 8'h0B, 0, 0, 0);
    step();
    check("skid_b_in_ready", 64'(In_Ready), 64'd0);
    check("skid_b_hold_a", 64'(Out_Data), 64'hA);
    drive(1, 32'hC, 8'h0C, 0, 0, 0);
    step();
    step();
    check("skid_stall_hold_a", 64'(Out_Data), 64'hA);
    check("skid_stall_ctrl_a", 64'(Out_Ctrl), 64'h0A);
    check("skid_stall_in_ready", 64'(In_Ready), 64'd0);
    drive(1, 32'hC, 8'h0C, 1, 0, 0);
    step();
    check("skid_rel_b", 64'(Out_Data), 64'hB);
    check("skid_rel_in_ready", 64'(In_Ready), 64'd1);
    step();
    check("skid_rel_c", 64'(Out_Data), 64'hC);
    drive(0, '0, '0, 1, 0, 0);
    step();
    check("skid_rel_empty", 64'(Out_Valid), 64'd0);

    // Flush in SKID with a same-cycle offer of 0xD
    drive(1, 32'hE, 8'h0E, 0, 0, 0);
    step();
    drive(1, 32'hF, 8'h0F, 0, 0, 0);
    step();
    check("flush_pre_skid", 64'(In_Ready), 64'd0);
    drive(1, 32'hD, 8'h0D, 0, 1, 0);
    step();
    check("flush_out_valid", 64'(Out_Valid), 64'd0);
    check("flush_out_ctrl", 64'(Out_Ctrl), 64'd0);
    check("flush_in_ready", 64'(In_Ready), 64'd1);
    check("flush_data_held", 64'(Out_Data), 64'hE);
    drive(0, '0, '0, 1, 0, 0);
    step();
    check("flush_d_dropped", 64'(Out_Valid), 64'd0);

    // Reset while FULL and stalled
    drive(1, 32'h55, 8'h55, 0, 0, 0);
    step();
    check("rstfull_valid", 64'(Out_Valid), 64'd1);
    drive(1, 32'h66, 8'h66, 0, 0, 1);
    step();
    check("rstfull_out_valid", 64'(Out_Valid), 64'd0);
    check("rstfull_out_data", 64'(Out_Data), 64'd0);
    check("rstfull_in_ready", 64'(In_Ready), 64'd1);
    drive(0, '0, '0, 1, 0, 0);
    step();
    check("rstfull_no_beat", 64'(Out_Valid), 64'd0);

`ifdef PIPE_STATS_EN
    // 5 stalls, 2 flushes of valid data, 1 flush while empty
    drive(0, '0, '0, 1, 0, 1);
    step();
    drive(1, 32'h1, 8'h1, 0, 0, 0);
    step();
    drive(0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step();
    drive(0, '0, '0, 1, 1, 0);
    step();
    drive(1, 32'h2, 8'h2, 1, 0, 0);
    step();
    drive(0, '0, '0, 1, 1, 0);
    step();
    step();
    drive(0, '0, '0, 1, 0, 0);
    step();
    check("stats_stall", 64'(Stall_Cnt), 64'd5);
    check("stats_flush", 64'(Flush_Cnt), 64'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, DATA_W'($urandom), CTRL_W'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
      step();
    end

    drive(0, '0, '0, 1, 0, 0);
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
